// File: rtl/vm_pkg.sv
// Shared coin codes and scheduler state encoding for the vending-machine front end.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_HALF = 2'b01,
    COIN_ONE  = 2'b10
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    VEND
  } sched_state_t;

endpackage

// File: rtl/vm_coin_fifo.sv
// Small coin FIFO: registered read/write pointers plus an occupancy count.
module vm_coin_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vm_coin_sched.sv
// Coin scheduler: pending latches, round-robin arbiter, coin FIFO and issue FSM.
// Optional sale/change statistics counters are built when SALE_STATS_EN is defined.
module vm_coin_sched
  import vm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
`ifdef SALE_STATS_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             coin_half,
  input  logic             coin_one,
  output logic [1:0]       vm_d_in,
  input  logic             vm_d_out,
  input  logic             vm_d_c,
  output logic             busy,
  output logic             fifo_full,
  output logic             coin_drop,
  output logic             sale,
  output logic             change
`ifdef SALE_STATS_EN
  , output logic [CNT_W-1:0] sale_cnt
  , output logic [CNT_W-1:0] change_cnt
`endif
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  sched_state_t state_q, state_d;
  coin_t        code_q, code_d, push_code;
  logic [GW-1:0] gap_q, gap_d;
  logic         got_out_q, got_out_d, got_c_q, got_c_d;
  logic         pend_half_q, pend_one_q, rr_q, drop_q;
  logic         grant_half, grant_one, push, pop, fifo_empty;
  logic [1:0]   fifo_rdata;

  // Round-robin only matters when both slots wait; rr=0 favours the half coin.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_half = 1'b0;
    grant_one  = 1'b0;
    if (!fifo_full) begin
      if (pend_half_q && pend_one_q) begin
        grant_half = !rr_q;
        grant_one  = rr_q;
      end else begin
        grant_half = pend_half_q;
        grant_one  = pend_one_q;
      end
    end
  end

  assign push      = grant_half | grant_one;
  assign push_code = grant_one ? COIN_ONE : COIN_HALF;

  vm_coin_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_code),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    gap_d     = gap_q;
    got_out_d = got_out_q;
    got_c_d   = got_c_q;
    pop       = 1'b0;
    vm_d_in   = COIN_NONE;
    sale      = 1'b0;
    change    = 1'b0;
    unique case (state_q)
      IDLE: ;
      ISSUE: begin
        vm_d_in   = code_q;
        gap_d     = GW'(GAP_CYCLES);
        got_out_d = got_out_q | vm_d_out;
        got_c_d   = got_c_q | vm_d_c;
        state_d   = WAIT;
      end
      WAIT: begin
        gap_d     = gap_q - GW'(1);
        got_out_d = got_out_q | vm_d_out;
        got_c_d   = got_c_q | vm_d_c;
        if (gap_q == GW'(1)) begin
          if (got_out_q || vm_d_out) begin
            state_d = VEND;
          end else begin
            got_out_d = 1'b0;
            got_c_d   = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      VEND: begin
        sale      = 1'b1;
        change    = got_c_q;
        got_out_d = 1'b0;
        got_c_d   = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Entering IDLE with work queued pops at once, so back-to-back coins sit GAP_CYCLES+1 apart.
    if (state_d == IDLE && !fifo_empty) begin
      pop     = 1'b1;
      code_d  = coin_t'(fifo_rdata);
      state_d = ISSUE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      code_q      <= COIN_NONE;
      gap_q       <= '0;
      got_out_q   <= 1'b0;
      got_c_q     <= 1'b0;
      pend_half_q <= 1'b0;
      pend_one_q  <= 1'b0;
      rr_q        <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      gap_q       <= gap_d;
      got_out_q   <= got_out_d;
      got_c_q     <= got_c_d;
      // A pulse landing on a set latch is discarded even if that latch is granted now.
      pend_half_q <= pend_half_q ? !grant_half : coin_half;
      pend_one_q  <= pend_one_q  ? !grant_one  : coin_one;
      if (push) rr_q <= !rr_q;
      drop_q      <= (coin_half & pend_half_q) | (coin_one & pend_one_q);
    end
  end

  assign coin_drop = drop_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef SALE_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sale_cnt   <= '0;
      change_cnt <= '0;
    end else begin
      if (sale && (sale_cnt != '1))     sale_cnt   <= sale_cnt + CNT_W'(1);
      if (change && (change_cnt != '1)) change_cnt <= change_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vm_coin_sched.sv
// Directed self-checking bench for vm_coin_sched (default build and SALE_STATS_EN build).
module tb_vm_coin_sched;
  import vm_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       coin_half = 1'b0, coin_one = 1'b0, vm_d_out = 1'b0, vm_d_c = 1'b0;
  logic [1:0] vm_d_in;
  logic       busy, fifo_full, coin_drop, sale, change;
`ifdef SALE_STATS_EN
  localparam int CW = 3;
  logic [CW-1:0] sale_cnt, change_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  vm_coin_sched #(
    .FIFO_DEPTH (4),
    .GAP_CYCLES (2)
`ifdef SALE_STATS_EN
    , .CNT_W    (CW)
`endif
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .coin_half  (coin_half),
    .coin_one   (coin_one),
    .vm_d_in    (vm_d_in),
    .vm_d_out   (vm_d_out),
    .vm_d_c     (vm_d_c),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .coin_drop  (coin_drop),
    .sale       (sale),
    .change     (change)
`ifdef SALE_STATS_EN
    , .sale_cnt   (sale_cnt)
    , .change_cnt (change_cnt)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    coin_half = 1'b0; coin_one = 1'b0; vm_d_out = 1'b0; vm_d_c = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    // Reset state and 20 quiet cycles.
    do_reset();
    check("rst_full", 8'(fifo_full), 8'h0);
    check("rst_drop", 8'(coin_drop), 8'h0);
    check("rst_change", 8'(change), 8'h0);
`ifdef SALE_STATS_EN
    check("rst_sale_cnt", 8'(sale_cnt), 8'h0);
    check("rst_change_cnt", 8'(change_cnt), 8'h0);
`endif
    for (int t = 0; t < 20; t++) begin
      check("quiet_vm", 8'(vm_d_in), 8'h0);
      check("quiet_busy", 8'(busy), 8'h0);
      check("quiet_sale", 8'(sale), 8'h0);
      tick();
    end

    // Single 1.0 coin pulsed in cycle 5: issued in cycle 8 only, idle again from 11.
    do_reset();
    for (int t = 0; t < 13; t++) begin
      coin_one = (t == 5);
      check("one_vm", 8'(vm_d_in), (t == 8) ? 8'(COIN_ONE) : 8'h0);
      check("one_busy", 8'(busy), 8'(t >= 7 && t <= 10));
      tick();
    end
    coin_one = 1'b0;

    // Both slots together with rr=0: half first, one three cycles later, no drop.
    do_reset();
    for (int t = 0; t < 10; t++) begin
      coin_half = (t == 0);
      coin_one  = (t == 0);
      check("both_vm", 8'(vm_d_in),
            (t == 3) ? 8'(COIN_HALF) : (t == 6) ? 8'(COIN_ONE) : 8'h0);
      check("both_drop", 8'(coin_drop), 8'h0);
      check("both_busy", 8'(busy), 8'(t >= 2 && t <= 8));
      tick();
    end

    // Fill FIFO plus both latches, then a half pulse on a set latch is dropped.
    do_reset();
    for (int t = 0; t < 11; t++) begin
      coin_half = (t % 2 == 0) && (t <= 8);
      coin_one  = (t == 0) || (t == 3) || (t == 5) || (t == 7);
      check("fill_vm", 8'(vm_d_in),
            (t == 3 || t == 9) ? 8'(COIN_HALF) : (t == 6) ? 8'(COIN_ONE) : 8'h0);
      check("fill_full", 8'(fifo_full), 8'(t == 7 || t == 8 || t == 10));
      check("fill_drop", 8'(coin_drop), 8'(t == 9));
      tick();
    end
    coin_half = 1'b0; coin_one = 1'b0;

    // Dispense with change after a 1.0 coin, then a dispense without change after a 0.5 coin.
    do_reset();
    for (int t = 0; t < 16; t++) begin
      coin_one  = (t == 0);
      coin_half = (t == 8);
      vm_d_out  = (t == 4) || (t == 13);
      vm_d_c    = (t == 4);
      check("vend_vm", 8'(vm_d_in),
            (t == 3) ? 8'(COIN_ONE) : (t == 11) ? 8'(COIN_HALF) : 8'h0);
      check("vend_sale", 8'(sale), 8'(t == 6 || t == 14));
      check("vend_change", 8'(change), 8'(t == 6));
`ifdef SALE_STATS_EN
      check("vend_sale_cnt", 8'(sale_cnt), (t >= 15) ? 8'h2 : (t >= 7) ? 8'h1 : 8'h0);
      check("vend_change_cnt", 8'(change_cnt), (t >= 7) ? 8'h1 : 8'h0);
`endif
      tick();
    end
    coin_one = 1'b0; coin_half = 1'b0; vm_d_out = 1'b0; vm_d_c = 1'b0;

`ifdef SALE_STATS_EN
    // Eight more sales with change push both 3-bit counters past 7; they must stick at 7.
    vm_d_out = 1'b1;
    vm_d_c   = 1'b1;
    for (int t = 0; t < 64; t++) begin
      coin_one = (t % 8 == 0);
      tick();
    end
    coin_one = 1'b0; vm_d_out = 1'b0; vm_d_c = 1'b0;
    tick();
    check("sat_sale_cnt", 8'(sale_cnt), 8'h7);
    check("sat_change_cnt", 8'(change_cnt), 8'h7);
`endif

    // Reset during ISSUE with three coins queued: output drops at once, nothing issues later.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      coin_half = (t == 0) || (t == 2) || (t == 4);
      coin_one  = (t == 0) || (t == 3) || (t == 5);
      tick();
    end
    coin_half = 1'b0; coin_one = 1'b0;
    check("mid_vm", 8'(vm_d_in), 8'(COIN_ONE));
    check("mid_busy", 8'(busy), 8'h1);
    Reset = 1'b1;
    #1;
    check("async_vm", 8'(vm_d_in), 8'h0);
    check("async_busy", 8'(busy), 8'h0);
    tick();
    tick();
    Reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      check("post_vm", 8'(vm_d_in), 8'h0);
      check("post_busy", 8'(busy), 8'h0);
      check("post_full", 8'(fifo_full), 8'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
